vga_timing_gen: RTL
===================

# vga_timing_gen

- Display timing generator for the 640x480 @ 60 Hz VGA path.
- Runs from the pixel clock and produces the raster coordinates `pix_row`/`pix_col` consumed by the track and sprite color generators.
- Produces `hsync`, `vsync` and `video_on`, delayed so they line up with the registered color outputs of those generators.
- Produces a once-per-frame `frame_tick` that game logic uses to update during vertical blanking.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, horizontal sync width (cycles)
- `H_BACK`, 48, horizontal back porch (cycles)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 1, pipeline stages on `hsync`/`vsync`/`video_on` (legal range 1..4)

Ports:
- `clk`  in  1  pixel clock, 25 MHz; all logic is on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `scroll_speed`  in  4  rows added to `scroll_offset` per frame
- `pix_col`  out  10  horizontal counter, 0..799
- `pix_row`  out  10  vertical counter, 0..524
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `video_on`  out  1  high while the pixel is in the visible area
- `frame_tick`  out  1  one-cycle pulse, once per frame
- `scroll_offset`  out  10  vertical road scroll position, 0..479

## Operation
- Horizontal counter `hcnt`:
  - increments every cycle;
  - wraps from H_TOTAL-1 (799) to 0.
- Vertical counter `vcnt`:
  - increments when `hcnt` wraps;
  - wraps from V_TOTAL-1 (524) to 0.
- H_TOTAL and V_TOTAL are the sums of the four horizontal and four vertical parameters respectively.
- `pix_col` = `hcnt` and `pix_row` = `vcnt`, driven directly from the counter registers.
- Outside the visible area the coordinates keep counting above 639/479. Downstream blocks use this to render black there.
- Decoded signals, computed from the counters:
  - hsync_d = !(hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for cols 656..751
  - vsync_d = !(vcnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for rows 490..491
  - video_on_d = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE)
- The decoded signals pass through a SYNC_DELAY-stage register pipeline before reaching the ports.
- `frame_tick`:
  - registered;
  - high for exactly one cycle, the cycle after the counters read row 480, col 0 (first blanking line).
- `scroll_offset`:
  - see Configuration;
  - `scroll_speed` is sampled only on the cycle `frame_tick` is high, so changes mid-frame have no effect until the next tick.

## Timing
- Reset values, applied asynchronously and immediately:
  - `hcnt` = 0, `vcnt` = 0
  - `hsync` = 1, `vsync` = 1 (inactive)
  - `video_on` = 0, `frame_tick` = 0, `scroll_offset` = 0
  - every delay-pipeline stage holds its inactive value
- Reset release: the first rising edge after deassertion advances `hcnt` to 1.
- Latency:
  - `hsync`/`vsync`/`video_on` at cycle t+SYNC_DELAY reflect the counters at cycle t.
  - With the default of 1 they align with a color generator that registers its output once.
- Periods:
  - line = 800 cycles
  - frame = 420000 cycles
  - `frame_tick` spacing = 420000 cycles
- Reset asserted mid-frame:
  - all outputs take their reset values within the same cycle;
  - no partial sync pulse is extended.
- Counter wrap and `frame_tick` never coincide; no simultaneous-event priority is needed.

## Configuration
Macro `VGA_SCROLL_EN`:
- Defined:
  - on each `frame_tick` cycle, `scroll_offset` <= (`scroll_offset` + `scroll_speed`) mod V_VISIBLE;
  - implemented as: if the sum is >= 480, subtract 480;
  - `scroll_speed` = 0 holds the offset.
- Undefined:
  - `scroll_offset` is constant 0;
  - `scroll_speed` is ignored;
  - the ports remain present.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 640x480 timing constants;
  - the derived H_TOTAL/V_TOTAL and sync start/end constants;
  - the sync polarity constant (active-low);
  - the 12-bit color width.
- Sub-module `sync_delay_line`: a parameterized N-stage, W-bit shift register with a reset value input, instanced once for {hsync, vsync, video_on}.

## Test plan
- Reset asserted at `pix_col`=300, `pix_row`=100 -> same cycle: `pix_col`=0, `pix_row`=0, `hsync`=1, `vsync`=1, `video_on`=0.
- Free run from reset -> `hsync` low for exactly 96 cycles per line, falling edge one cycle after `pix_col`=656; line period 800 cycles.
- Full frame -> `vsync` low for exactly 1600 cycles starting one cycle after row 490 col 0; `vsync` falling edges exactly 420000 cycles apart.
- Row 10 -> `video_on` high 640 consecutive cycles; falls one cycle after `pix_col` 639->640; low for all of rows 480..524.
- `frame_tick` -> exactly one pulse per 420000 cycles, observed the cycle after row 480 col 0.
- `VGA_SCROLL_EN` defined:
  - `scroll_speed`=5, offset 475 -> 0 after the next tick;
  - `scroll_speed` changed to 7 mid-frame -> offset advances by 7 only at the following tick;
  - macro undefined -> `scroll_offset` stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing constants for the VGA display path.
package vga_timing_pkg;

    localparam int C_H_VISIBLE = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;
    localparam int C_V_VISIBLE = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;

    localparam int C_H_TOTAL    = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;
    localparam int C_V_TOTAL    = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;
    localparam int C_HSYNC_START = C_H_VISIBLE + C_H_FRONT;
    localparam int C_HSYNC_END   = C_H_VISIBLE + C_H_FRONT + C_H_SYNC - 1;
    localparam int C_VSYNC_START = C_V_VISIBLE + C_V_FRONT;
    localparam int C_VSYNC_END   = C_V_VISIBLE + C_V_FRONT + C_V_SYNC - 1;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   COLOR_W     = 12;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// N-stage, W-bit shift register whose stages reset to a supplied value.
module sync_delay_line #(
    parameter int N = 1,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) stage_q[i] <= rst_val;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, delayed sync/blanking and per-frame tick.
// Road scrolling accumulator is built only when VGA_SCROLL_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = C_H_VISIBLE,
    parameter int H_FRONT    = C_H_FRONT,
    parameter int H_SYNC     = C_H_SYNC,
    parameter int H_BACK     = C_H_BACK,
    parameter int V_VISIBLE  = C_V_VISIBLE,
    parameter int V_FRONT    = C_V_FRONT,
    parameter int V_SYNC     = C_V_SYNC,
    parameter int V_BACK     = C_V_BACK,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] scroll_speed,
    output logic [9:0] pix_col,
    output logic [9:0] pix_row,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick,
    output logic [9:0] scroll_offset
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       frame_tick_q, frame_tick_d;
    logic       hsync_d, vsync_d, video_on_d;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = 10'd0;
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
    end

    always_comb begin
        hsync_d      = (hcnt_q >= HS_START && hcnt_q <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = (vcnt_q >= VS_START && vcnt_q <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_d   = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        frame_tick_d = (hcnt_q == 10'd0) && (vcnt_q == V_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q       <= 10'd0;
            vcnt_q       <= 10'd0;
            frame_tick_q <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Delay matches the registered color outputs of the downstream generators.
    sync_delay_line #(
        .N (SYNC_DELAY),
        .W (3)
    ) u_sync_delay (
        .clk     (clk),
        .reset   (reset),
        .rst_val ({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0}),
        .din     ({hsync_d, vsync_d, video_on_d}),
        .dout    ({hsync, vsync, video_on})
    );

`ifdef VGA_SCROLL_EN
    logic [9:0]  scroll_q, scroll_d;
    logic [10:0] scroll_sum;

    always_comb begin
        scroll_sum = {1'b0, scroll_q} + {7'd0, scroll_speed};
        scroll_d   = scroll_q;
        if (frame_tick_q) begin
            scroll_d = (scroll_sum >= 11'(V_VISIBLE)) ? 10'(scroll_sum - 11'(V_VISIBLE))
                                                      : scroll_sum[9:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) scroll_q <= 10'd0;
        else       scroll_q <= scroll_d;
    end

    assign scroll_offset = scroll_q;
`else
    logic scroll_unused;
    assign scroll_unused = ^scroll_speed;
    assign scroll_offset = 10'd0;
`endif

    assign pix_col    = hcnt_q;
    assign pix_row    = vcnt_q;
    assign frame_tick = frame_tick_q;

endmodule
